// File: rtl/cmd_reply_packer.sv
// cmd_reply_packer
//   Collects 16-bit command replies (ping / read-register) into one 252-word
//   buffer and drains it as a fixed 256-word control packet:
//   header (2 words), adc_time stamp (2 words), payload, zero padding.
//
// Ports
//   txclk          in   clock, rising edge
//   reset_n        in   asynchronous active-low reset
//   adc_time       in   timestamp latched when a packet is flushed
//   rx_databus     in   reply word from the command reader
//   rx_WR          in   reply word strobe
//   rx_WR_done     in   high between replies
//   rx_WR_enabled  out  reader may start / continue a reply
//   usb_space      in   downstream FIFO can take a full packet
//   usb_data       out  packet word
//   usb_wr         out  usb_data valid (256-cycle burst)
//   overflow       out  sticky: a reply word was dropped
//
// Build option
//   CMD_REPLY_TIMEOUT_EN  defined: replies accumulate until the buffer is
//                         nearly full or FLUSH_TIMEOUT idle cycles pass.
//                         undefined: every reply boundary flushes a packet.
//
// state      | meaning
// COLLECT    | accepting reply words into the buffer
// WAIT_SPACE | packet sealed, waiting for usb_space
// HDR0/HDR1  | emitting header low / high word
// TS0/TS1    | emitting timestamp low / high word
// PAYLOAD    | emitting buffered reply words
// PAD        | emitting zero fill up to word 255
module cmd_reply_packer #(
  parameter int         FLUSH_TIMEOUT = 1024,
  parameter logic [4:0] CHAN          = 5'h1F
) (
  input  logic        txclk,
  input  logic        reset_n,
  input  logic [31:0] adc_time,
  input  logic [15:0] rx_databus,
  input  logic        rx_WR,
  input  logic        rx_WR_done,
  output logic        rx_WR_enabled,
  input  logic        usb_space,
  output logic [15:0] usb_data,
  output logic        usb_wr,
  output logic        overflow
);

  localparam logic [7:0] BUF_WORDS = 8'd252;

  typedef enum logic [2:0] {COLLECT, WAIT_SPACE, HDR0, HDR1, TS0, TS1, PAYLOAD, PAD} state_t;

  state_t      state;
  state_t      drain_state_nxt;
  logic [15:0] pkt_buf [0:251];
  logic [7:0]  wr_ptr;
  logic [7:0]  free;
  logic [7:0]  free_nxt;
  logic [7:0]  wcnt;
  logic [7:0]  wcnt_nxt;
  logic [7:0]  pay_idx;
  logic [8:0]  len_bytes;
  logic [31:0] ts;
  logic [31:0] header;
  logic [15:0] word_nxt;
  logic        reply_open;
  logic        reply_open_nxt;
  logic        word_wr;
  logic        word_drop;
  logic        flush;
  logic        timeout_hit;
  logic        draining;
  logic        last_word;
  logic        collect_nxt;
  logic        enable_nxt;

  assign free      = BUF_WORDS - wr_ptr;
  assign word_wr   = (state == COLLECT) && rx_WR && (free != 8'd0);
  assign word_drop = rx_WR && !word_wr;
  assign draining  = (state != COLLECT) && (state != WAIT_SPACE);
  assign last_word = (wcnt == 8'd255);
  assign header    = {3'b000, 1'b1, 1'b1, 6'd0, CHAN, 7'd0, len_bytes};

  // Never evaluated with rx_WR high, so a reply is never split across packets.
  assign flush = (state == COLLECT) && (wr_ptr != 8'd0) && rx_WR_done && !rx_WR &&
                 ((free < 8'd4) || timeout_hit);

`ifdef CMD_REPLY_TIMEOUT_EN
  localparam int                IDLE_W     = $clog2(FLUSH_TIMEOUT) + 1;
  localparam logic [IDLE_W-1:0] IDLE_MAX   = '1;
  localparam logic [IDLE_W-1:0] IDLE_LIMIT = IDLE_W'(FLUSH_TIMEOUT - 1);

  logic [IDLE_W-1:0] idle_cnt;

  always_ff @(posedge txclk or negedge reset_n) begin
    if (!reset_n)
      idle_cnt <= '0;
    else if (rx_WR || flush)
      idle_cnt <= '0;
    else if ((wr_ptr != 8'd0) && (idle_cnt != IDLE_MAX))
      idle_cnt <= idle_cnt + 1'b1;
  end

  assign timeout_hit = (idle_cnt == IDLE_LIMIT);
`else
  // No idle counter: any reply boundary flushes. FLUSH_TIMEOUT has no effect here.
  assign timeout_hit = (FLUSH_TIMEOUT > 0) || 1'b1;
`endif

  // Next word of the drain burst, selected by its index wcnt+1.
  always_comb begin
    wcnt_nxt        = wcnt + 8'd1;
    pay_idx         = wcnt - 8'd3;
    word_nxt        = 16'h0000;
    drain_state_nxt = PAD;
    if (wcnt_nxt == 8'd1) begin
      word_nxt        = header[31:16];
      drain_state_nxt = HDR1;
    end else if (wcnt_nxt == 8'd2) begin
      word_nxt        = ts[15:0];
      drain_state_nxt = TS0;
    end else if (wcnt_nxt == 8'd3) begin
      word_nxt        = ts[31:16];
      drain_state_nxt = TS1;
    end else if (pay_idx < wr_ptr) begin
      word_nxt        = pkt_buf[pay_idx];
      drain_state_nxt = PAYLOAD;
    end
  end

  // rx_WR_enabled is registered, so it is computed from next-cycle values.
  always_comb begin
    reply_open_nxt = rx_WR_done ? 1'b0 : (rx_WR ? 1'b1 : reply_open);
    collect_nxt    = ((state == COLLECT) && !flush) || (draining && last_word);
    free_nxt       = (state == COLLECT) ? (free - {7'd0, word_wr}) : BUF_WORDS;
    enable_nxt     = collect_nxt && (reply_open_nxt ? (free_nxt >= 8'd1) : (free_nxt >= 8'd4));
  end

  always_ff @(posedge txclk) begin
    if (word_wr)
      pkt_buf[wr_ptr] <= rx_databus;
  end

  always_ff @(posedge txclk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= COLLECT;
      wr_ptr        <= 8'd0;
      wcnt          <= 8'd0;
      reply_open    <= 1'b0;
      ts            <= 32'd0;
      len_bytes     <= 9'd0;
      rx_WR_enabled <= 1'b0;
      usb_wr        <= 1'b0;
      usb_data      <= 16'h0000;
      overflow      <= 1'b0;
    end else begin
      reply_open    <= reply_open_nxt;
      rx_WR_enabled <= enable_nxt;
      if (word_drop)
        overflow <= 1'b1;
      case (state)
        COLLECT: begin
          if (word_wr)
            wr_ptr <= wr_ptr + 8'd1;
          if (flush) begin
            ts        <= adc_time;
            len_bytes <= {wr_ptr, 1'b0};
            state     <= WAIT_SPACE;
          end
        end
        WAIT_SPACE: begin
          if (usb_space) begin
            state    <= HDR0;
            wcnt     <= 8'd0;
            usb_wr   <= 1'b1;
            usb_data <= header[15:0];
          end
        end
        default: begin
          if (last_word) begin
            state    <= COLLECT;
            wr_ptr   <= 8'd0;
            usb_wr   <= 1'b0;
            usb_data <= 16'h0000;
          end else begin
            wcnt     <= wcnt_nxt;
            usb_data <= word_nxt;
            state    <= drain_state_nxt;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cmd_reply_packer.sv
module tb_cmd_reply_packer;

  logic        txclk;
  logic        reset_n;
  logic [31:0] adc_time;
  logic [15:0] rx_databus;
  logic        rx_WR;
  logic        rx_WR_done;
  logic        rx_WR_enabled;
  logic        usb_space;
  logic [15:0] usb_data;
  logic        usb_wr;
  logic        overflow;

  cmd_reply_packer dut (
    .txclk         (txclk),
    .reset_n       (reset_n),
    .adc_time      (adc_time),
    .rx_databus    (rx_databus),
    .rx_WR         (rx_WR),
    .rx_WR_done    (rx_WR_done),
    .rx_WR_enabled (rx_WR_enabled),
    .usb_space     (usb_space),
    .usb_data      (usb_data),
    .usb_wr        (usb_wr),
    .overflow      (overflow)
  );

  initial txclk = 1'b0;
  always #5 txclk = ~txclk;

  int n_tests = 0;
  int n_fail  = 0;
  int run     = 0;

  logic [15:0] expq [$];
  logic [15:0] pend [$];
  logic [15:0] e;

  typedef struct {
    int               n;
    logic [3:0][15:0] w;
    logic [31:0]      ts;
    logic [15:0]      hdr0;
  } vec_t;

  vec_t vt [5];

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  function automatic vec_t mk(input int n, input logic [15:0] a, input logic [15:0] b,
                              input logic [15:0] c, input logic [15:0] d,
                              input logic [31:0] ts, input logic [15:0] h);
    vec_t v;
    v.n    = n;
    v.w[0] = a;
    v.w[1] = b;
    v.w[2] = c;
    v.w[3] = d;
    v.ts   = ts;
    v.hdr0 = h;
    return v;
  endfunction

  // Expected packet: header, timestamp, payload collected so far, zero pad.
  function automatic void push_packet(input logic [15:0] hdr0, input logic [31:0] ts);
    int cnt;
    expq.push_back(hdr0);
    expq.push_back(16'h181F);
    expq.push_back(ts[15:0]);
    expq.push_back(ts[31:16]);
    cnt = 4 + pend.size();
    while (pend.size() != 0) expq.push_back(pend.pop_front());
    for (int k = cnt; k < 256; k++) expq.push_back(16'h0000);
  endfunction

  // Scoreboard: every usb_wr word is popped and compared; bursts must be 256 long.
  always @(negedge txclk) begin
    if (!reset_n) begin
      run = 0;
    end else if (usb_wr) begin
      run++;
      if (expq.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL extra_word: got %h expected no word", usb_data);
      end else begin
        e = expq.pop_front();
        check("usb_data", {16'h0, usb_data}, {16'h0, e});
      end
    end else if (run != 0) begin
      check("burst_len", run, 256);
      run = 0;
    end
  end

  task automatic send_reply(input logic [3:0][15:0] w, input int n, input logic [31:0] ts);
    int t = 0;
    @(posedge txclk); #1;
    while (!rx_WR_enabled && t < 3000) begin
      @(posedge txclk); #1;
      t++;
    end
    check("enable_wait", {31'd0, rx_WR_enabled}, 32'd1);
    adc_time = ts;
    for (int k = 0; k < n; k++) begin
      rx_WR_done = 1'b0;
      rx_WR      = 1'b1;
      rx_databus = w[k];
      pend.push_back(w[k]);
      @(posedge txclk); #1;
    end
    rx_WR      = 1'b0;
    rx_WR_done = 1'b1;
  endtask

  task automatic wait_drain();
    int t = 0;
    while ((expq.size() != 0 || usb_wr) && t < 3000) begin
      @(posedge txclk); #1;
      t++;
    end
    @(posedge txclk); #1;
    check("drain_left", expq.size(), 0);
  endtask

  // Called while word 0 is on usb_data; strikes during the payload words.
  task automatic pulse_overrun();
    check("overflow_pre", {31'd0, overflow}, 32'd0);
    repeat (5) @(posedge txclk);
    #1;
    rx_WR      = 1'b1;
    rx_databus = 16'hDEAD;
    @(posedge txclk); #1;
    rx_WR = 1'b0;
    check("overflow_set", {31'd0, overflow}, 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0][15:0] w;
    int bad;
    int t;

    vt[0] = mk(2, 16'h0102, 16'hBEEF, 16'h0000, 16'h0000, 32'h0000_1000, 16'h0004);
    vt[1] = mk(4, 16'h0201, 16'h0010, 16'h1234, 16'h5678, 32'hDEAD_BEEF, 16'h0008);
    vt[2] = mk(2, 16'hFFFF, 16'h0000, 16'h0000, 16'h0000, 32'h0000_0000, 16'h0004);
    vt[3] = mk(4, 16'hA5A5, 16'h5A5A, 16'h8001, 16'h7FFE, 32'h1234_5678, 16'h0008);
    vt[4] = mk(2, 16'h0000, 16'hFFFF, 16'h0000, 16'h0000, 32'hFFFF_FFFF, 16'h0004);

    reset_n    = 1'b0;
    adc_time   = 32'd0;
    rx_databus = 16'h0;
    rx_WR      = 1'b0;
    rx_WR_done = 1'b1;
    usb_space  = 1'b1;
    repeat (3) @(posedge txclk);
    #1;
    check("rst_enable", {31'd0, rx_WR_enabled}, 32'd0);
    check("rst_usb_wr", {31'd0, usb_wr}, 32'd0);
    check("rst_usb_data", {16'd0, usb_data}, 32'd0);
    check("rst_overflow", {31'd0, overflow}, 32'd0);
    reset_n = 1'b1;
    @(posedge txclk); #1;
    check("enable_after_rst", {31'd0, rx_WR_enabled}, 32'd1);

    for (int i = 0; i < 5; i++) begin
      send_reply(vt[i].w, vt[i].n, vt[i].ts);
      push_packet(vt[i].hdr0, vt[i].ts);
      wait_drain();
    end

`ifndef CMD_REPLY_TIMEOUT_EN
    // Flush-to-first-word latency and overrun during PAYLOAD.
    w = {16'h0, 16'h0, 16'h4455, 16'h1122};
    send_reply(w, 2, 32'hAABB_CCDD);
    push_packet(16'h0004, 32'hAABB_CCDD);
    @(posedge txclk); #1;
    check("lat_wr_cycle1", {31'd0, usb_wr}, 32'd0);
    check("en_low_after_flush", {31'd0, rx_WR_enabled}, 32'd0);
    @(posedge txclk); #1;
    check("lat_wr_cycle2", {31'd0, usb_wr}, 32'd1);
    pulse_overrun();
    wait_drain();

    // Two back-to-back pings become two packets.
    w = {16'h0, 16'h0, 16'h0B0B, 16'h0A0A};
    send_reply(w, 2, 32'h0000_0011);
    push_packet(16'h0004, 32'h0000_0011);
    w = {16'h0, 16'h0, 16'h0D0D, 16'h0C0C};
    send_reply(w, 2, 32'h0000_0022);
    push_packet(16'h0004, 32'h0000_0022);
    wait_drain();
`else
    // Idle-timeout flush of a lone ping, with overrun during the drain.
    w = {16'h0, 16'h0, 16'hBEEF, 16'h0102};
    send_reply(w, 2, 32'h0000_1000);
    push_packet(16'h0004, 32'h0000_1000);
    repeat (1015) @(posedge txclk);
    #1;
    check("timeout_not_yet", {30'd0, usb_wr, rx_WR_enabled}, 32'd1);
    t = 0;
    while (!usb_wr && t < 100) begin
      @(posedge txclk); #1;
      t++;
    end
    check("timeout_flush", {31'd0, usb_wr}, 32'd1);
    pulse_overrun();
    wait_drain();

    // Fill to capacity: 63 read-register replies.
    for (int r = 0; r < 63; r++) begin
      for (int k = 0; k < 4; k++) w[k] = 16'((r << 8) | k);
      send_reply(w, 4, 32'hCAFE_0001);
    end
    @(posedge txclk); #1;
    check("fill_en_drop", {31'd0, rx_WR_enabled}, 32'd0);
    push_packet(16'h01F8, 32'hCAFE_0001);
    wait_drain();

    // Admission: 249 words buffered, free 3 -> no new reply, flush at boundary.
    for (int r = 0; r < 62; r++) begin
      for (int k = 0; k < 4; k++) w[k] = 16'h8000 | 16'((r << 4) | k);
      send_reply(w, 4, 32'h0BAD_F00D);
    end
    w = {16'h0, 16'h0, 16'h0, 16'h7777};
    send_reply(w, 1, 32'h0BAD_F00D);
    @(posedge txclk); #1;
    check("admit_en_low", {31'd0, rx_WR_enabled}, 32'd0);
    push_packet(16'h01F2, 32'h0BAD_F00D);
    wait_drain();
`endif

    // Back-pressure, then reset in the middle of the drain.
    usb_space = 1'b0;
    w = {16'h0, 16'h0, 16'h2222, 16'h1111};
    send_reply(w, 2, 32'h0000_0055);
    push_packet(16'h0004, 32'h0000_0055);
    bad = 0;
`ifdef CMD_REPLY_TIMEOUT_EN
    repeat (1030) begin
      @(posedge txclk); #1;
      if (usb_wr) bad++;
    end
`endif
    repeat (100) begin
      @(posedge txclk); #1;
      if (usb_wr) bad++;
    end
    check("bp_hold", bad, 0);
    usb_space = 1'b1;
    @(posedge txclk); #1;
    check("bp_start", {31'd0, usb_wr}, 32'd1);
    repeat (100) @(posedge txclk);
    #1;
    reset_n = 1'b0;
    #1;
    check("midrst_usb_wr", {31'd0, usb_wr}, 32'd0);
    check("midrst_usb_data", {16'd0, usb_data}, 32'd0);
    check("midrst_enable", {31'd0, rx_WR_enabled}, 32'd0);
    check("midrst_overflow", {31'd0, overflow}, 32'd0);
    expq.delete();
    pend.delete();
    repeat (2) @(posedge txclk);
    #1;
    reset_n = 1'b1;

    // Stale buffer contents must be gone: a fresh ping gives len 4.
    w = {16'h0, 16'h0, 16'h9999, 16'h8888};
    send_reply(w, 2, 32'h0000_0077);
    push_packet(16'h0004, 32'h0000_0077);
    wait_drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
